// File: rtl/dmem_responder_if.sv
// Request/response bus between the CPU MEM stage (master) and the data-memory responder (slave).
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] address;
   logic        read_enable;
   logic        write_enable;
   logic [63:0] write_data;
   logic [3:0]  xfer_size;
   logic        resp_valid;
   logic [63:0] read_data;
   logic        error;

   modport master (
      output req_valid, address, read_enable, write_enable, write_data, xfer_size,
      input  req_ready, resp_valid, read_data, error
   );

   modport slave (
      input  req_valid, address, read_enable, write_enable, write_data, xfer_size,
      output req_ready, resp_valid, read_data, error
   );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle byte-addressable little-endian data memory with programmable latency
// and error responses for malformed requests; one request in flight at a time.
module dmem_responder #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned LATENCY    = 2
) (
   input  logic            clk,
   input  logic            rst,
   dmem_responder_if.slave bus
);
   localparam int unsigned CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int unsigned MEM_BYTES = 2 ** ADDR_WIDTH;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                  state, state_nxt;
   logic [CNT_W-1:0]        cnt, cnt_nxt;
   logic [7:0]              mem [MEM_BYTES];
   logic [ADDR_WIDTH-1:0]   lat_addr;
   logic [3:0]              lat_size;
   logic                    lat_write;
   logic [63:0]             lat_wdata;
   logic                    accept, size_ok, align_ok, range_ok, dir_ok, legal;
   logic [63:0]             rd_word, rdata_nxt;
   logic                    err_nxt, commit;

   // Request legality decode
   always_comb begin
      size_ok  = bus.xfer_size inside {4'd1, 4'd2, 4'd4, 4'd8};
      align_ok = (bus.address[2:0] & 3'(bus.xfer_size - 4'd1)) == 3'd0;
      range_ok = (bus.address >> ADDR_WIDTH) == 64'd0;
      dir_ok   = bus.read_enable != bus.write_enable;
      legal    = size_ok && align_ok && range_ok && dir_ok;
      accept   = bus.req_valid && (state == IDLE);
   end

   // Load path: gather the latched transfer's bytes, zero above the size
   always_comb begin
      rd_word = 64'd0;
      for (int i = 0; i < 8; i++) begin
         if (4'(i) < lat_size) rd_word[8*i +: 8] = mem[lat_addr + ADDR_WIDTH'(i)];
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      rdata_nxt = 64'd0;
      err_nxt   = 1'b0;
      commit    = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) begin
               if (legal) begin
                  state_nxt = WAIT;
                  cnt_nxt   = CNT_W'(LATENCY - 1);
               end else begin
                  state_nxt = RESP;
                  err_nxt   = 1'b1;
               end
            end
         end
         WAIT: begin
            if (cnt == '0) begin
               state_nxt = RESP;
               commit    = lat_write;
               rdata_nxt = lat_write ? 64'd0 : rd_word;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (accept && !rst) begin
         lat_addr  <= bus.address[ADDR_WIDTH-1:0];
         lat_size  <= bus.xfer_size;
         lat_write <= bus.write_enable;
         lat_wdata <= bus.write_data;
      end
   end

   // Store commit on the edge entering RESP; storage is deliberately not reset
   always_ff @(posedge clk) begin
      if (commit && !rst) begin
         for (int i = 0; i < 8; i++) begin
            if (4'(i) < lat_size) mem[lat_addr + ADDR_WIDTH'(i)] <= lat_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.req_ready  <= 1'b1;
         bus.resp_valid <= 1'b0;
         bus.read_data  <= 64'd0;
         bus.error      <= 1'b0;
      end else begin
         bus.req_ready  <= state_nxt == IDLE;
         bus.resp_valid <= state_nxt == RESP;
         if (state_nxt == RESP) begin
            bus.read_data <= rdata_nxt;
            bus.error     <= err_nxt;
         end
      end
   end
endmodule
